// File: rtl/mux4_to_1_rr.sv
// mux4_to_1_rr: four-lane round-robin stream merger.
// Each cycle at most one lane is granted. Its word is captured into a single
// output register and tagged with the source lane index. A 2-bit pointer
// records where the next priority scan starts. It moves one past the lane
// that was just granted, so every requesting lane is served within four grants.

module mux4_to_1_rr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid0,
    input  logic             in_valid1,
    input  logic             in_valid2,
    input  logic             in_valid3,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic             in_ready0,
    output logic             in_ready1,
    output logic             in_ready2,
    output logic             in_ready3,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);

    logic [3:0]       valid_vec;
    logic [WIDTH-1:0] data_arr [4];
    logic [1:0]       ptr;
    logic             load_en;
    logic             found;
    logic [1:0]       winner;
    logic [3:0]       grant;

    assign valid_vec   = {in_valid3, in_valid2, in_valid1, in_valid0};
    assign data_arr[0] = in_data0;
    assign data_arr[1] = in_data1;
    assign data_arr[2] = in_data2;
    assign data_arr[3] = in_data3;

    // The output register can take a word when it is empty or is being drained this cycle.
    assign load_en = !out_valid || out_ready;

    // Priority scan starting at ptr: the first valid lane wins. Only valid bits are inspected.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = 2'd0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = ptr + 2'(k);
            if (!found && valid_vec[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // One-hot grant. It is suppressed during reset, while the register is stalled, or when no lane is valid.
    always_comb begin
        grant = 4'b0000;
        if (!reset && load_en && found) begin
            grant[winner] = 1'b1;
        end
    end

    assign in_ready0 = grant[0];
    assign in_ready1 = grant[1];
    assign in_ready2 = grant[2];
    assign in_ready3 = grant[3];

    // Output register and priority pointer. Reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
        end else if (load_en && found) begin
            out_valid <= 1'b1;
            out_data  <= data_arr[winner];
            out_sel   <= winner;
            ptr       <= winner + 2'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
